z_core_mem_bridge: RTL and testbench



---
 rtl/z_core_mem_bridge.sv | 191 +++++++++++++++++++
 tb/tb_z_core_mem_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z_core_mem_bridge.sv
// z_core_mem_bridge: converts the core's single-word memory request into a
// request/response valid-ready transaction, rejects misaligned accesses
// locally and reports completion with a one-cycle core_ready pulse.
// Optional build macro MEM_TIMEOUT_EN bounds the time spent in REQ+RESP to
// TIMEOUT_CYCLES cycles and completes with an error when the bound is hit.
module z_core_mem_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_wstrb,
  output logic [31:0]       core_rdata,
  output logic              core_ready,
  output logic              core_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_rerr,
  output logic              bus_rready
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                bus_valid_d;
  logic                bus_rready_d;
  logic                bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_d;
  logic                core_ready_d;
  logic                core_err_d;
  logic [DATA_W-1:0]   core_rdata_d;
  logic                misaligned_c;
  logic                timeout_c;

  assign misaligned_c = (core_addr[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;

  // Counter reaches TIMEOUT_CYCLES on the edge that ends this cycle
  assign timeout_c = ((state_q == REQ) || (state_q == RESP)) &&
                     ((to_cnt_q + TO_W'(1)) == TO_W'(TIMEOUT_CYCLES));

  // Wait counter: cleared when a request is issued, counts in REQ and RESP
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_q == IDLE) && core_req && !misaligned_c) begin
      to_cnt_d = '0;
    end else if ((state_q == REQ) || (state_q == RESP)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Wait counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d      = state_q;
    bus_valid_d  = bus_valid;
    bus_rready_d = bus_rready;
    bus_we_d     = bus_we;
    bus_addr_d   = bus_addr;
    bus_wdata_d  = bus_wdata;
    bus_wstrb_d  = bus_wstrb;
    core_ready_d = 1'b0;
    core_err_d   = core_err;
    core_rdata_d = core_rdata;

    case (state_q)
      IDLE: begin
        if (core_req) begin
          if (misaligned_c) begin
            // Rejected locally, the bus never sees it
            state_d      = DONE;
            core_err_d   = 1'b1;
            core_rdata_d = '0;
          end else begin
            state_d     = REQ;
            bus_valid_d = 1'b1;
            bus_we_d    = core_we;
            bus_addr_d  = {core_addr[ADDR_W-1:2], 2'b00};
            bus_wdata_d = core_wdata;
            bus_wstrb_d = core_we ? core_wstrb : STRB_W'(0);
          end
        end
      end

      REQ: begin
        if (timeout_c) begin
          state_d      = DONE;
          bus_valid_d  = 1'b0;
          bus_rready_d = 1'b0;
          core_err_d   = 1'b1;
          core_rdata_d = '0;
        end else if (bus_ready) begin
          // A response arriving alongside bus_ready waits for RESP
          state_d      = RESP;
          bus_valid_d  = 1'b0;
          bus_rready_d = 1'b1;
        end
      end

      RESP: begin
        if (timeout_c) begin
          state_d      = DONE;
          bus_valid_d  = 1'b0;
          bus_rready_d = 1'b0;
          core_err_d   = 1'b1;
          core_rdata_d = '0;
        end else if (bus_rvalid) begin
          state_d      = DONE;
          bus_rready_d = 1'b0;
          core_err_d   = bus_rerr;
          core_rdata_d = bus_we ? DATA_W'(0) : bus_rdata;
        end
      end

      DONE: begin
        state_d      = IDLE;
        core_ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bus_valid  <= 1'b0;
      bus_rready <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
      core_ready <= 1'b0;
      core_err   <= 1'b0;
      core_rdata <= '0;
    end else begin
      state_q    <= state_d;
      bus_valid  <= bus_valid_d;
      bus_rready <= bus_rready_d;
      bus_we     <= bus_we_d;
      bus_addr   <= bus_addr_d;
      bus_wdata  <= bus_wdata_d;
      bus_wstrb  <= bus_wstrb_d;
      core_ready <= core_ready_d;
      core_err   <= core_err_d;
      core_rdata <= core_rdata_d;
    end
  end

endmodule

// File: tb/tb_z_core_mem_bridge.sv
// Directed testbench for z_core_mem_bridge. Inputs are driven and outputs
// sampled 1 ns after each rising edge. Timeout checks are built only when
// MEM_TIMEOUT_EN is defined (bridge built with TIMEOUT_CYCLES = 8).
module tb_z_core_mem_bridge;

  logic        clk;
  logic        reset;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic [31:0] core_rdata;
  logic        core_ready;
  logic        core_err;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_rerr;
  logic        bus_rready;

  int n_tests = 0;
  int n_fail  = 0;

  z_core_mem_bridge #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_wstrb (core_wstrb),
    .core_rdata (core_rdata),
    .core_ready (core_ready),
    .core_err   (core_err),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .bus_rerr   (bus_rerr),
    .bus_rready (bus_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_addr  = 32'h0;
    core_wdata = 32'h0;
    core_wstrb = 4'h0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    bus_rerr   = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_bus_valid", 32'(bus_valid), 32'h0);
    check("rst_bus_rready", 32'(bus_rready), 32'h0);
    check("rst_core_ready", 32'(core_ready), 32'h0);
    check("rst_core_err", 32'(core_err), 32'h0);
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    reset = 1'b0;
    tick();

    // Aligned read, slave always ready, rvalid already high
    core_req   = 1'b1;
    core_we    = 1'b0;
    core_addr  = 32'h0000_0040;
    core_wstrb = 4'hF;
    bus_ready  = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hCAFE_F00D;
    tick();
    core_req = 1'b0;
    check("rd_bus_valid", 32'(bus_valid), 32'h1);
    check("rd_bus_addr", bus_addr, 32'h0000_0040);
    check("rd_bus_wstrb", 32'(bus_wstrb), 32'h0);
    check("rd_bus_we", 32'(bus_we), 32'h0);
    check("rd_rready_in_req", 32'(bus_rready), 32'h0);
    tick();
    check("rd_resp_valid", 32'(bus_valid), 32'h0);
    check("rd_resp_rready", 32'(bus_rready), 32'h1);
    tick();
    check("rd_done_rready", 32'(bus_rready), 32'h0);
    check("rd_done_no_ready", 32'(core_ready), 32'h0);
    tick();
    check("rd_core_ready", 32'(core_ready), 32'h1);
    check("rd_core_rdata", core_rdata, 32'hCAFE_F00D);
    check("rd_core_err", 32'(core_err), 32'h0);
    bus_rvalid = 1'b0;
    tick();
    check("rd_pulse_end", 32'(core_ready), 32'h0);
    check("rd_rdata_held", core_rdata, 32'hCAFE_F00D);

    // Write with bus_ready held off for three cycles
    core_req   = 1'b1;
    core_we    = 1'b1;
    core_addr  = 32'h0000_0100;
    core_wdata = 32'h1234_5678;
    core_wstrb = 4'b0011;
    bus_ready  = 1'b0;
    bus_rdata  = 32'hDEAD_BEEF;
    tick();
    // Conflicting core inputs while busy must be ignored
    core_addr  = 32'h0000_0003;
    core_wdata = 32'h0BAD_0BAD;
    core_wstrb = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_valid_%0d", i), 32'(bus_valid), 32'h1);
      check($sformatf("wr_addr_%0d", i), bus_addr, 32'h0000_0100);
      check($sformatf("wr_wdata_%0d", i), bus_wdata, 32'h1234_5678);
      check($sformatf("wr_wstrb_%0d", i), 32'(bus_wstrb), 32'h3);
      check($sformatf("wr_we_%0d", i), 32'(bus_we), 32'h1);
      if (i < 2) tick();
    end
    core_req  = 1'b0;
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    check("wr_resp_valid", 32'(bus_valid), 32'h0);
    check("wr_resp_rready", 32'(bus_rready), 32'h1);
    tick();
    check("wr_wait_rready", 32'(bus_rready), 32'h1);
    check("wr_wait_no_ready", 32'(core_ready), 32'h0);
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    tick();
    check("wr_core_ready", 32'(core_ready), 32'h1);
    check("wr_core_rdata", core_rdata, 32'h0);
    check("wr_core_err", 32'(core_err), 32'h0);

    // Misaligned read: no bus activity, completes one edge later
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 32'h0000_0102;
    bus_ready = 1'b1;
    tick();
    core_req = 1'b0;
    check("mis_no_valid0", 32'(bus_valid), 32'h0);
    check("mis_no_ready0", 32'(core_ready), 32'h0);
    tick();
    check("mis_core_ready", 32'(core_ready), 32'h1);
    check("mis_core_err", 32'(core_err), 32'h1);
    check("mis_core_rdata", core_rdata, 32'h0);
    check("mis_no_valid1", 32'(bus_valid), 32'h0);
    tick();
    check("mis_pulse_end", 32'(core_ready), 32'h0);

    // Read returning a slave error
    core_req  = 1'b1;
    core_addr = 32'h0000_0200;
    tick();
    core_req = 1'b0;
    tick();
    bus_rvalid = 1'b1;
    bus_rerr   = 1'b1;
    bus_rdata  = 32'hFFFF_FFFF;
    tick();
    bus_rvalid = 1'b0;
    bus_rerr   = 1'b0;
    bus_rdata  = 32'h0;
    tick();
    check("err_core_ready", 32'(core_ready), 32'h1);
    check("err_core_err", 32'(core_err), 32'h1);
    check("err_core_rdata", core_rdata, 32'hFFFF_FFFF);
    // Stray response while idle is not consumed and changes nothing
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h5555_5555;
    tick();
    tick();
    check("stray_rready", 32'(bus_rready), 32'h0);
    check("err_held_rdata", core_rdata, 32'hFFFF_FFFF);
    check("err_held_err", 32'(core_err), 32'h1);
    bus_rvalid = 1'b0;

    // Reset while waiting in RESP
    core_req  = 1'b1;
    core_addr = 32'h0000_0300;
    tick();
    core_req = 1'b0;
    tick();
    check("rst_mid_rready_pre", 32'(bus_rready), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_rready", 32'(bus_rready), 32'h0);
    check("rst_mid_valid", 32'(bus_valid), 32'h0);
    check("rst_mid_ready", 32'(core_ready), 32'h0);
    tick();
    check("rst_mid_no_pulse", 32'(core_ready), 32'h0);

    // Normal read after the reset
    core_req   = 1'b1;
    core_addr  = 32'h0000_0304;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hA5A5_5A5A;
    tick();
    core_req = 1'b0;
    check("post_rst_valid", 32'(bus_valid), 32'h1);
    check("post_rst_addr", bus_addr, 32'h0000_0304);
    tick();
    tick();
    check("post_rst_no_ready", 32'(core_ready), 32'h0);
    tick();
    check("post_rst_ready", 32'(core_ready), 32'h1);
    check("post_rst_rdata", core_rdata, 32'hA5A5_5A5A);
    check("post_rst_err", 32'(core_err), 32'h0);
    bus_rvalid = 1'b0;
    tick();

`ifdef MEM_TIMEOUT_EN
    // Slave never accepts: request abandoned after 8 cycles
    bus_ready = 1'b0;
    core_req  = 1'b1;
    core_addr = 32'h0000_0400;
    tick();
    core_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("to_valid_%0d", i), 32'(bus_valid), 32'h1);
      tick();
    end
    check("to_valid_drop", 32'(bus_valid), 32'h0);
    check("to_rready", 32'(bus_rready), 32'h0);
    check("to_no_ready_yet", 32'(core_ready), 32'h0);
    tick();
    check("to_core_ready", 32'(core_ready), 32'h1);
    check("to_core_err", 32'(core_err), 32'h1);
    check("to_core_rdata", core_rdata, 32'h0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0000_1234;
    tick();
    tick();
    check("to_late_rready", 32'(bus_rready), 32'h0);
    check("to_late_rdata", core_rdata, 32'h0);
    check("to_late_ready", 32'(core_ready), 32'h0);
    bus_rvalid = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
